spk_serializer: RTL

- Downstream neighbour of the 5-bank spike detector.
- Captures each valid 5-bank beat (5 × 32-bit samples plus 5 × 12-bit channel numbers) into a beat FIFO.
- Serialises each beat into a 32-bit word stream with a ready/valid handshake, for the host transfer path on bus_clk.
- Tracks frames, drops and overflow for host diagnostics.

---
 rtl/spk_serializer_if.sv | 23 ++
 rtl/spk_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spk_serializer_if.sv
// Beat input and word output handshake bundle of the spike serializer.
// Ports: muap_comb_* (5-bank beat in), dout_* (32-bit word stream out, ready/valid).
// slave = serializer side, master = producer/consumer side.
interface spk_serializer_if;
   logic         muap_comb_valid;
   logic [159:0] muap_comb_data;
   logic [59:0]  muap_comb_ch;
   logic         dout_ready;
   logic         dout_valid;
   logic [31:0]  dout_data;
   logic [11:0]  dout_ch;
   logic         dout_last;

   modport slave (
      input  muap_comb_valid, muap_comb_data, muap_comb_ch, dout_ready,
      output dout_valid, dout_data, dout_ch, dout_last
   );

   modport master (
      output muap_comb_valid, muap_comb_data, muap_comb_ch, dout_ready,
      input  dout_valid, dout_data, dout_ch, dout_last
   );
endinterface

// File: rtl/spk_serializer.sv
// Serialises 5-bank spike beats into a 32-bit word stream with optional frame headers.
// Latency: beat captured at edge N -> first word valid after edge N+2 (from idle).
// Backpressure: words hold while dout_ready=0; beats arriving with the FIFO full are dropped.
// Ports: bus_clk/bus_rst_n, ser_en (capture enable), clr (clear drop stats),
//        bus (spk_serializer_if.slave), frame_cnt/drop_cnt/overflow status.
// Macro SPK_SER_HDR_EN: when defined, frame-start beats are preceded by a header word.

// Small FIFO with look-ahead of the entry after the head (used for bubble-free chaining).
module spk_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             head_o,
   output logic [W-1:0]             next_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [AW:0]   count_q;

   assign rd_nxt = rd_ptr_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_nxt;
         count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign next_o  = mem_q[rd_nxt];
   assign count_o = count_q;
endmodule

module spk_serializer #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] HDR_MAGIC  = 16'hC0DE
) (
   input  logic                   bus_clk,
   input  logic                   bus_rst_n,
   input  logic                   ser_en,
   input  logic                   clr,
   spk_serializer_if.slave        bus,
   output logic [15:0]            frame_cnt,
   output logic [15:0]            drop_cnt,
   output logic                   overflow
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [59:0]  ch;
      logic [159:0] data;
   } beat_t;

   typedef struct packed {
      logic [31:0] data;
      logic [11:0] ch;
      logic        last;
   } word_t;

`ifdef SPK_SER_HDR_EN
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic          valid_q, valid_d;
   word_t         word_q, word_d;
   logic [15:0]   frame_q, frame_d;
   logic [15:0]   drop_q, drop_d;
   logic          ovf_q, ovf_d;
   logic          ne_q;

   beat_t         din, head, nxt, start_src;
   logic [CW-1:0] count;
   logic          full, push, pop, drop, xfer, start;

   function automatic word_t bank_word(beat_t b, logic [2:0] k);
      word_t w;
      w.data = b.data[32*k +: 32];
      w.ch   = b.ch[12*k +: 12];
      w.last = (k == 3'd4);
      return w;
   endfunction

   function automatic logic is_fs(beat_t b);
      return b.ch[11:0] == 12'd0;
   endfunction

   // Capture: full comes from the registered count, so a same-cycle pop never frees a slot.
   assign din  = '{ch: bus.muap_comb_ch, data: bus.muap_comb_data};
   assign full = (count == CW'(FIFO_DEPTH));
   assign push = bus.muap_comb_valid && ser_en && !full;
   assign drop = bus.muap_comb_valid && ser_en && full;

   spk_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (bus_clk),
      .rst_n   (bus_rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (din),
      .head_o  (head),
      .next_o  (nxt),
      .count_o (count)
   );

   assign xfer = valid_q && bus.dout_ready;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      word_d    = word_q;
      frame_d   = frame_q;
      pop       = 1'b0;
      start     = 1'b0;
      start_src = head;

      case (state_q)
         IDLE: begin
            if (ne_q) start = 1'b1;
         end
`ifdef SPK_SER_HDR_EN
         HDR: begin
            if (xfer) begin
               state_d = DATA;
               idx_d   = 3'd0;
               word_d  = bank_word(head, 3'd0);
            end
         end
`endif
         DATA: begin
            if (xfer) begin
               if (idx_q == 3'd4) begin
                  pop = 1'b1;
                  if (is_fs(head)) frame_d = frame_q + 16'd1;
                  // Chain straight into the following beat when one is already stored.
                  if (count > CW'(1)) begin
                     start     = 1'b1;
                     start_src = nxt;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end else begin
                  idx_d  = idx_q + 3'd1;
                  word_d = bank_word(head, idx_q + 3'd1);
               end
            end
         end
         default: ;
      endcase

      // First word of a beat; header carries the count after any pop made this cycle.
      if (start) begin
         valid_d = 1'b1;
         idx_d   = 3'd0;
`ifdef SPK_SER_HDR_EN
         if (is_fs(start_src)) begin
            state_d = HDR;
            word_d  = '{data: {HDR_MAGIC, frame_d}, ch: 12'hFFF, last: 1'b0};
         end else
`endif
         begin
            state_d = DATA;
            word_d  = bank_word(start_src, 3'd0);
         end
      end

      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (clr) begin
         drop_d = 16'd0;
         ovf_d  = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         word_q  <= '0;
         frame_q <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
         ne_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         word_q  <= word_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
         // Registered not-empty: adds the launch cycle out of idle. Forced low on a pop
         // so a just-emptied FIFO is never seen as holding a beat.
         ne_q    <= (count != '0) && !pop;
      end
   end

   assign bus.dout_valid = valid_q;
   assign bus.dout_data  = word_q.data;
   assign bus.dout_ch    = word_q.ch;
   assign bus.dout_last  = word_q.last;
   assign frame_cnt      = frame_q;
   assign drop_cnt       = drop_q;
   assign overflow       = ovf_q;
endmodule
